// File: rtl/dtc_pkg.sv
// Shared types and constants for the DTC serial-input deserializer.
package dtc_pkg;

  // Width of one deserialized word.
  localparam int DTC_WORD_W = 8;

  // Width of the lock/unlock counters; it holds thresholds up to 15.
  localparam int DTC_CNT_W = 4;

  // Default alignment/idle word sent by the far-end serializer.
  localparam logic [DTC_WORD_W-1:0] DTC_SYNC_WORD = 8'hBC;

  // Word-alignment state machine states.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } dtc_state_t;

endpackage

// File: rtl/dtc_lock_fsm.sv
// Word-alignment state machine for the DTC deserializer.
// HUNT waits for the sync word at any bit offset and restarts the phase
// counter there. VERIFY needs LOCK_CNT consecutive aligned sync words.
// LOCKED drops back to HUNT after UNLOCK_CNT sync words seen at a
// non-boundary offset, or at once on realign.
module dtc_lock_fsm
  import dtc_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic bitclk,
  input  logic reset,
  input  logic hit,        // the window completed on this edge is the sync word
  input  logic boundary,   // this edge completes a word at the current phase
  input  logic realign,
  output logic locked,
  output logic phase_clr,  // restart the phase counter on this edge
  output logic word_emit   // present the completed word on this edge
);

  localparam logic [DTC_CNT_W-1:0] LOCK_TGT   = DTC_CNT_W'(LOCK_CNT);
  localparam logic [DTC_CNT_W-1:0] UNLOCK_TGT = DTC_CNT_W'(UNLOCK_CNT);

  dtc_state_t state_reg, state_next;
  logic [DTC_CNT_W-1:0] good_cnt_reg, good_cnt_next;
  logic [DTC_CNT_W-1:0] bad_cnt_reg, bad_cnt_next;
  logic [DTC_CNT_W-1:0] good_inc;
  logic [DTC_CNT_W-1:0] bad_inc;

  // good_cnt never exceeds LOCK_CNT, so it needs no saturation.
  assign good_inc = good_cnt_reg + DTC_CNT_W'(1);
  assign bad_inc  = (bad_cnt_reg == '1) ? bad_cnt_reg : bad_cnt_reg + DTC_CNT_W'(1);

  // State and counter registers.
  always_ff @(posedge bitclk) begin
    if (reset) begin
      state_reg    <= HUNT;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
    end
  end

  // Next-state and counter updates; realign overrides every other rule.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    if (realign) begin
      state_next    = HUNT;
      good_cnt_next = '0;
      bad_cnt_next  = '0;
    end else begin
      unique case (state_reg)
        HUNT: begin
          if (hit) begin
            state_next    = VERIFY;
            good_cnt_next = DTC_CNT_W'(1);
            bad_cnt_next  = '0;
          end
        end
        VERIFY: begin
          // Sync words off the boundary are ignored while verifying.
          if (boundary) begin
            if (hit) begin
              good_cnt_next = good_inc;
              if (good_inc == LOCK_TGT) begin
                state_next   = LOCKED;
                bad_cnt_next = '0;
              end
            end else begin
              state_next    = HUNT;
              good_cnt_next = '0;
            end
          end
        end
        LOCKED: begin
          // An aligned sync word proves the phase and forgives earlier
          // misaligned hits.
          if (boundary) begin
            if (hit) begin
              bad_cnt_next = '0;
            end
          end else if (hit) begin
            bad_cnt_next = bad_inc;
            if (bad_inc == UNLOCK_TGT) begin
              state_next    = HUNT;
              good_cnt_next = '0;
              bad_cnt_next  = '0;
            end
          end
        end
        default: begin
          state_next    = HUNT;
          good_cnt_next = '0;
          bad_cnt_next  = '0;
        end
      endcase
    end
  end

  // Moore lock flag plus the edge qualifiers the datapath needs.
  always_comb begin
    locked    = (state_reg == LOCKED);
    phase_clr = (state_reg == HUNT) && hit && !realign;
    word_emit = (state_reg == LOCKED) && boundary && !realign;
  end

endmodule

// File: rtl/dtc_din_deser.sv
// DTC serial-input deserializer: shifts MSB-first bits in on every bitclk,
// finds word alignment on SYNC_WORD and, once locked, presents each
// completed word on dtc_pdout with a one-cycle dtc_pvalid strobe.
module dtc_din_deser
  import dtc_pkg::*;
#(
  parameter logic [DTC_WORD_W-1:0] SYNC_WORD  = DTC_SYNC_WORD,
  parameter int                    LOCK_CNT   = 4,
  parameter int                    UNLOCK_CNT = 4
) (
  input  logic                  bitclk,
  input  logic                  reset,
  input  logic                  dtc_sdin,
  input  logic                  realign,
  output logic [DTC_WORD_W-1:0] dtc_pdout,
  output logic                  dtc_pvalid,
  output logic                  dtc_psync,
  output logic                  locked
);

  localparam int                PHASE_W    = $clog2(DTC_WORD_W);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DTC_WORD_W - 1);

  // Only the newest W-1 bits are kept: the oldest bit of a full word
  // register would shift out before it could ever be used.
  logic [DTC_WORD_W-2:0] sr_reg;
  logic [DTC_WORD_W-1:0] nxt;
  logic [PHASE_W-1:0]    phase_reg;
  logic [DTC_WORD_W-1:0] pdout_reg;
  logic                  pvalid_reg;
  logic                  psync_reg;
  logic                  hit;
  logic                  boundary;
  logic                  phase_clr;
  logic                  word_emit;

  // The window completed on this edge: stored bits with the incoming bit as LSB.
  assign nxt[0] = dtc_sdin;
  generate
    for (genvar gi = 1; gi < DTC_WORD_W; gi++) begin : g_window
      assign nxt[gi] = sr_reg[gi-1];
    end
  endgenerate

  assign hit      = (nxt == SYNC_WORD);
  assign boundary = (phase_reg == PHASE_LAST);

  // Serial history shift register.
  always_ff @(posedge bitclk) begin
    if (reset) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= nxt[DTC_WORD_W-2:0];
    end
  end

  // Free-running bit phase; a sync hit in HUNT restarts it so the next
  // boundary lines up with the end of the following word.
  always_ff @(posedge bitclk) begin
    if (reset) begin
      phase_reg <= '0;
    end else if (phase_clr) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + PHASE_W'(1);
    end
  end

  // Output registers: load on an emitted boundary, strobe for one cycle.
  always_ff @(posedge bitclk) begin
    if (reset) begin
      pdout_reg  <= '0;
      pvalid_reg <= 1'b0;
      psync_reg  <= 1'b0;
    end else begin
      pvalid_reg <= word_emit;
      psync_reg  <= word_emit && hit;
      if (word_emit) begin
        pdout_reg <= nxt;
      end
    end
  end

  dtc_lock_fsm #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock_fsm (
    .bitclk    (bitclk),
    .reset     (reset),
    .hit       (hit),
    .boundary  (boundary),
    .realign   (realign),
    .locked    (locked),
    .phase_clr (phase_clr),
    .word_emit (word_emit)
  );

  assign dtc_pdout  = pdout_reg;
  assign dtc_pvalid = pvalid_reg;
  assign dtc_psync  = psync_reg;

endmodule

// File: doc/dtc_din_deser.md
DTC_DIN_DESER -- requirements
Module: dtc_din_deser

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hBC: alignment/idle word sent by the far-end serializer.
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive aligned SYNC_WORDs needed to declare lock (range 2..15).
REQ-003 SHALL have parameter UNLOCK_CNT, default 4: consecutive misaligned SYNC_WORD hits that drop lock (range 1..15).
REQ-004 SHALL have port: bitclk  input  1  bit-rate clock, all logic on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: dtc_sdin  input  1  serial data, MSB of each word first, one bit per bitclk.
REQ-007 SHALL have port: realign  input  1  one-cycle request to drop lock and re-hunt.
REQ-008 SHALL have port: dtc_pdout  output  8  last deserialized word.
REQ-009 SHALL have port: dtc_pvalid  output  1  one-cycle strobe, dtc_pdout updated and locked.
REQ-010 SHALL have port: dtc_psync  output  1  qualifies dtc_pvalid, word equals SYNC_WORD.
REQ-011 SHALL have port: locked  output  1  alignment achieved.

Function
REQ-012 SHALL shift every cycle: sr <= {sr[6:0], dtc_sdin}; nxt denotes {sr[6:0], dtc_sdin}.
REQ-013 SHALL keep a 3-bit phase counter incrementing every cycle, wrapping 7->0; word boundary = edge with phase==7.
REQ-014 SHALL implement FSM states HUNT, VERIFY, LOCKED; locked=1 only in LOCKED.
REQ-015 HUNT: any edge with nxt==SYNC_WORD SHALL set phase<=0, good_cnt<=1, go VERIFY; otherwise phase free-runs.
REQ-016 VERIFY: at boundary, nxt==SYNC_WORD SHALL increment good_cnt; when incremented value == LOCK_CNT, go LOCKED.
REQ-017 VERIFY: at boundary, nxt!=SYNC_WORD SHALL clear good_cnt and return to HUNT.
REQ-018 LOCKED: at each boundary SHALL load dtc_pdout<=nxt, pulse dtc_pvalid high for the following cycle only, dtc_psync<=(nxt==SYNC_WORD).
REQ-019 Latency SHALL be one bitclk: pvalid asserted in the cycle after the last bit (LSB) of a word is sampled.
REQ-020 LOCKED: nxt==SYNC_WORD at non-boundary SHALL increment bad_cnt (saturating); aligned SYNC_WORD at boundary SHALL clear bad_cnt.
REQ-021 LOCKED: bad_cnt reaching UNLOCK_CNT SHALL go HUNT on that edge, locked low next cycle, no further pvalid.
REQ-022 If misaligned hit and boundary coincide (impossible by definition) no rule needed; aligned hit at boundary SHALL take priority over bad_cnt.
REQ-023 realign=1 in any state SHALL force HUNT on that edge, clear good_cnt/bad_cnt; pvalid SHALL not pulse for a boundary on that edge.
REQ-024 In HUNT/VERIFY, dtc_pvalid and dtc_psync SHALL stay 0; dtc_pdout SHALL hold last value.
REQ-025 dtc_pvalid SHALL never be high on two consecutive cycles; in LOCKED its period SHALL be exactly 8 cycles.

Reset
REQ-026 reset SHALL set sr=0, phase=0, good_cnt=0, bad_cnt=0, state=HUNT.
REQ-027 reset SHALL drive dtc_pdout=8'h00, dtc_pvalid=0, dtc_psync=0, locked=0 in the cycle after the reset edge.
REQ-028 reset asserted mid-word or while LOCKED SHALL abandon the word; no pvalid for it; re-hunt after release.

Structure
REQ-029 Package dtc_pkg SHALL hold the FSM state typedef (HUNT/VERIFY/LOCKED), DTC_WORD_W=8, default SYNC_WORD 8'hBC.
REQ-030 Lock FSM with good/bad counters SHALL be sub-module dtc_lock_fsm; shift register, phase counter, output registers in top.
REQ-031 SHALL be fully compatible with dtc_dout_ser output: MSB first, new word every 8 bitclk, no gaps.

Verification
REQ-032 Reset, then 6 x 8'hBC at arbitrary bit offset 3 -> locked=1 after 4th aligned BC; pvalid with psync=1 every 8 cycles.
REQ-033 Locked, send BC,12,A5,FF -> pdout 8'h12, 8'hA5, 8'hFF, pvalid exactly 1 cycle after each LSB, psync=0 for those.
REQ-034 In VERIFY after 2 BC, inject 8'h00 at boundary -> HUNT, locked stays 0, no pvalid.
REQ-035 Locked, slip stream by one bit, send continuous BC -> 4 misaligned hits drop lock, re-lock at new phase after 4 aligned BC.
REQ-036 Locked, pulse realign -> locked=0 next cycle, no pvalid that boundary, re-lock after 4 BC.
REQ-037 Assert reset mid-word while locked -> all outputs 0 next cycle, locked=0 until re-hunt completes.
